// File: rtl/wshb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wshb_arbiter
// Purpose  : Two-requester Wishbone arbiter sharing one SDRAM Wishbone port
//            between the VGA frame reader (requester 0) and the pattern
//            (mire) writer (requester 1). The VGA reader never drops cyc, so
//            ownership is taken back after MAX_BURST completed transfers
//            whenever the other requester is waiting.
// Ports    : wshb_clk_i / wshb_rst_n_i  clock, asynchronous active-low reset
//            vga_*      slave side, requester 0 (adr, dat_ms, dat_sm, sel,
//                       cti, bte, we, cyc, stb, ack, err, rty)
//            mire_*     slave side, requester 1 (same fields)
//            mst_*      master side towards the SDRAM controller
//            gnt_vga_o  requester 0 owns the bus (decoded from state reg)
//            gnt_mire_o requester 1 owns the bus (decoded from state reg)
// Revision : 1.0  initial release
// ============================================================================
module wshb_arbiter #(
  parameter int MAX_BURST = 16
) (
  input  logic        wshb_clk_i,
  input  logic        wshb_rst_n_i,
  // requester 0 : VGA reader
  input  logic [31:0] vga_adr_i,
  input  logic [31:0] vga_dat_ms_i,
  output logic [31:0] vga_dat_sm_o,
  input  logic [3:0]  vga_sel_i,
  input  logic [2:0]  vga_cti_i,
  input  logic [1:0]  vga_bte_i,
  input  logic        vga_we_i,
  input  logic        vga_cyc_i,
  input  logic        vga_stb_i,
  output logic        vga_ack_o,
  output logic        vga_err_o,
  output logic        vga_rty_o,
  // requester 1 : pattern writer
  input  logic [31:0] mire_adr_i,
  input  logic [31:0] mire_dat_ms_i,
  output logic [31:0] mire_dat_sm_o,
  input  logic [3:0]  mire_sel_i,
  input  logic [2:0]  mire_cti_i,
  input  logic [1:0]  mire_bte_i,
  input  logic        mire_we_i,
  input  logic        mire_cyc_i,
  input  logic        mire_stb_i,
  output logic        mire_ack_o,
  output logic        mire_err_o,
  output logic        mire_rty_o,
  // master : SDRAM controller
  output logic [31:0] mst_adr_o,
  output logic [31:0] mst_dat_ms_o,
  input  logic [31:0] mst_dat_sm_i,
  output logic [3:0]  mst_sel_o,
  output logic [2:0]  mst_cti_o,
  output logic [1:0]  mst_bte_o,
  output logic        mst_we_o,
  output logic        mst_cyc_o,
  output logic        mst_stb_o,
  input  logic        mst_ack_i,
  input  logic        mst_err_i,
  input  logic        mst_rty_i,
  // grants
  output logic        gnt_vga_o,
  output logic        gnt_mire_o
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  // encoding of the round-robin pointer: last owner served
  localparam logic LAST_VGA  = 1'b0;
  localparam logic LAST_MIRE = 1'b1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_MIRE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;

  logic          req_vga, req_mire;
  logic          own_mire, own_req, oth_req, own_stb, xfer_end;
  logic [CW-1:0] cnt_inc;
  state_t        other_own;

  assign req_vga  = vga_cyc_i & vga_stb_i;
  assign req_mire = mire_cyc_i & mire_stb_i;

  // Owner-relative view so both OWN states share one set of rules.
  assign own_mire  = (state_q == OWN_MIRE);
  assign own_req   = own_mire ? req_mire : req_vga;
  assign oth_req   = own_mire ? req_vga : req_mire;
  assign own_stb   = own_mire ? mire_stb_i : vga_stb_i;
  assign other_own = own_mire ? OWN_VGA : OWN_MIRE;
  // rty retries the same transfer, so only ack/err consume budget
  assign xfer_end  = (mst_ack_i | mst_err_i) & own_stb;
  assign cnt_inc   = cnt_q + CNT_ONE;

  always_ff @(posedge wshb_clk_i or negedge wshb_rst_n_i) begin
    if (!wshb_rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= LAST_MIRE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        // On a tie the requester that was not served last wins.
        if (req_vga && (!req_mire || last_q == LAST_MIRE)) begin
          state_d = OWN_VGA;
        end else if (req_mire) begin
          state_d = OWN_MIRE;
        end
      end
      OWN_VGA, OWN_MIRE: begin
        if (xfer_end) begin
          if (cnt_inc == BURST_LAST) begin
            // Budget spent: reload, and hand over straight away if the
            // other side is waiting (no IDLE bubble).
            cnt_d = '0;
            if (oth_req) begin
              state_d = other_own;
              last_d  = own_mire ? LAST_MIRE : LAST_VGA;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end else if (!own_req) begin
          cnt_d   = '0;
          last_d  = own_mire ? LAST_MIRE : LAST_VGA;
          state_d = oth_req ? other_own : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Request/response steering is purely combinational from the state so the
  // arbiter adds no latency to the slave's ack path.
  always_comb begin
    mst_adr_o    = '0;
    mst_dat_ms_o = '0;
    mst_sel_o    = '0;
    mst_cti_o    = '0;
    mst_bte_o    = '0;
    mst_we_o     = 1'b0;
    mst_cyc_o    = 1'b0;
    mst_stb_o    = 1'b0;
    vga_ack_o    = 1'b0;
    vga_err_o    = 1'b0;
    vga_rty_o    = 1'b0;
    mire_ack_o   = 1'b0;
    mire_err_o   = 1'b0;
    mire_rty_o   = 1'b0;
    case (state_q)
      OWN_VGA: begin
        mst_adr_o    = vga_adr_i;
        mst_dat_ms_o = vga_dat_ms_i;
        mst_sel_o    = vga_sel_i;
        mst_cti_o    = vga_cti_i;
        mst_bte_o    = vga_bte_i;
        mst_we_o     = vga_we_i;
        mst_cyc_o    = vga_cyc_i;
        mst_stb_o    = vga_stb_i;
        vga_ack_o    = mst_ack_i;
        vga_err_o    = mst_err_i;
        vga_rty_o    = mst_rty_i;
      end
      OWN_MIRE: begin
        mst_adr_o    = mire_adr_i;
        mst_dat_ms_o = mire_dat_ms_i;
        mst_sel_o    = mire_sel_i;
        mst_cti_o    = mire_cti_i;
        mst_bte_o    = mire_bte_i;
        mst_we_o     = mire_we_i;
        mst_cyc_o    = mire_cyc_i;
        mst_stb_o    = mire_stb_i;
        mire_ack_o   = mst_ack_i;
        mire_err_o   = mst_err_i;
        mire_rty_o   = mst_rty_i;
      end
      default: ;
    endcase
  end

  // Read data needs no steering: only the owner can be waiting on it.
  assign vga_dat_sm_o  = mst_dat_sm_i;
  assign mire_dat_sm_o = mst_dat_sm_i;

  assign gnt_vga_o  = (state_q == OWN_VGA);
  assign gnt_mire_o = (state_q == OWN_MIRE);

endmodule
`default_nettype wire

// File: tb/tb_wshb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wshb_arbiter
// Purpose  : Self-checking bench. Two arbiters (MAX_BURST 16 and 1) share the
//            same requesters and slave response; a behavioural model tracks
//            owner / transfer count / last-served per instance and every
//            output group is compared on each falling edge.
// Revision : 1.0  initial release
// ============================================================================
module tb_wshb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  always #5 clk = ~clk;

  // requester and slave stimulus
  logic [31:0] v_adr, v_dat, mi_adr, mi_dat, s_dat;
  logic [3:0]  v_sel, mi_sel;
  logic [2:0]  v_cti, mi_cti;
  logic [1:0]  v_bte, mi_bte;
  logic        v_we, v_cyc, v_stb, mi_we, mi_cyc, mi_stb;
  logic        s_ack, s_err, s_rty;

  // per-instance DUT outputs
  logic [31:0] o_adr [2];
  logic [31:0] o_dat [2];
  logic [3:0]  o_sel [2];
  logic [2:0]  o_cti [2];
  logic [1:0]  o_bte [2];
  logic        o_we  [2];
  logic        o_cyc [2];
  logic        o_stb [2];
  logic [31:0] o_vdat [2];
  logic [31:0] o_mdat [2];
  logic        o_vack [2];
  logic        o_verr [2];
  logic        o_vrty [2];
  logic        o_mack [2];
  logic        o_merr [2];
  logic        o_mrty [2];
  logic        o_gv  [2];
  logic        o_gm  [2];

  wshb_arbiter #(.MAX_BURST(16)) u_arb16 (
    .wshb_clk_i(clk), .wshb_rst_n_i(rst_n),
    .vga_adr_i(v_adr), .vga_dat_ms_i(v_dat), .vga_dat_sm_o(o_vdat[0]),
    .vga_sel_i(v_sel), .vga_cti_i(v_cti), .vga_bte_i(v_bte), .vga_we_i(v_we),
    .vga_cyc_i(v_cyc), .vga_stb_i(v_stb),
    .vga_ack_o(o_vack[0]), .vga_err_o(o_verr[0]), .vga_rty_o(o_vrty[0]),
    .mire_adr_i(mi_adr), .mire_dat_ms_i(mi_dat), .mire_dat_sm_o(o_mdat[0]),
    .mire_sel_i(mi_sel), .mire_cti_i(mi_cti), .mire_bte_i(mi_bte), .mire_we_i(mi_we),
    .mire_cyc_i(mi_cyc), .mire_stb_i(mi_stb),
    .mire_ack_o(o_mack[0]), .mire_err_o(o_merr[0]), .mire_rty_o(o_mrty[0]),
    .mst_adr_o(o_adr[0]), .mst_dat_ms_o(o_dat[0]), .mst_dat_sm_i(s_dat),
    .mst_sel_o(o_sel[0]), .mst_cti_o(o_cti[0]), .mst_bte_o(o_bte[0]), .mst_we_o(o_we[0]),
    .mst_cyc_o(o_cyc[0]), .mst_stb_o(o_stb[0]),
    .mst_ack_i(s_ack), .mst_err_i(s_err), .mst_rty_i(s_rty),
    .gnt_vga_o(o_gv[0]), .gnt_mire_o(o_gm[0])
  );

  wshb_arbiter #(.MAX_BURST(1)) u_arb1 (
    .wshb_clk_i(clk), .wshb_rst_n_i(rst_n),
    .vga_adr_i(v_adr), .vga_dat_ms_i(v_dat), .vga_dat_sm_o(o_vdat[1]),
    .vga_sel_i(v_sel), .vga_cti_i(v_cti), .vga_bte_i(v_bte), .vga_we_i(v_we),
    .vga_cyc_i(v_cyc), .vga_stb_i(v_stb),
    .vga_ack_o(o_vack[1]), .vga_err_o(o_verr[1]), .vga_rty_o(o_vrty[1]),
    .mire_adr_i(mi_adr), .mire_dat_ms_i(mi_dat), .mire_dat_sm_o(o_mdat[1]),
    .mire_sel_i(mi_sel), .mire_cti_i(mi_cti), .mire_bte_i(mi_bte), .mire_we_i(mi_we),
    .mire_cyc_i(mi_cyc), .mire_stb_i(mi_stb),
    .mire_ack_o(o_mack[1]), .mire_err_o(o_merr[1]), .mire_rty_o(o_mrty[1]),
    .mst_adr_o(o_adr[1]), .mst_dat_ms_o(o_dat[1]), .mst_dat_sm_i(s_dat),
    .mst_sel_o(o_sel[1]), .mst_cti_o(o_cti[1]), .mst_bte_o(o_bte[1]), .mst_we_o(o_we[1]),
    .mst_cyc_o(o_cyc[1]), .mst_stb_o(o_stb[1]),
    .mst_ack_i(s_ack), .mst_err_i(s_err), .mst_rty_i(s_rty),
    .gnt_vga_o(o_gv[1]), .gnt_mire_o(o_gm[1])
  );

  // model: owner 0 = nobody, 1 = VGA, 2 = mire; last in {1,2}
  int bmax [2] = '{16, 1};
  int own  [2];
  int cnt  [2];
  int last [2];
  int vacks [2];
  int macks [2];
  int total = 0;
  int bad   = 0;
  int cyc_n = 0;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      own[k] = 0; cnt[k] = 0; last[k] = 2;
    end
  endtask

  task automatic model_step(input int k);
    bit rv, rm, myreq, oreq, mystb, e;
    rv = v_cyc & v_stb;
    rm = mi_cyc & mi_stb;
    if (own[k] == 0) begin
      if (rv && rm)  own[k] = (last[k] == 1) ? 2 : 1;
      else if (rv)   own[k] = 1;
      else if (rm)   own[k] = 2;
    end else begin
      myreq = (own[k] == 1) ? rv : rm;
      oreq  = (own[k] == 1) ? rm : rv;
      mystb = (own[k] == 1) ? v_stb : mi_stb;
      e     = (s_ack | s_err) & mystb;
      if (e) begin
        cnt[k]++;
        if (cnt[k] == bmax[k]) begin
          cnt[k] = 0;
          if (oreq) begin
            last[k] = own[k];
            own[k]  = 3 - own[k];
          end
        end
      end else if (!myreq) begin
        cnt[k]  = 0;
        last[k] = own[k];
        own[k]  = oreq ? 3 - own[k] : 0;
      end
    end
  endtask

  task automatic cmp(input string name, input int k, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d cycle=%0d got=%h want=%h", name, k, cyc_n, act, exp);
    end
  endtask

  task automatic check_inst(input int k);
    logic [75:0] em, am;
    logic [5:0]  er, ar;
    em = '0;
    if (own[k] == 1) em = {v_cyc, v_stb, v_we, v_adr, v_dat, v_sel, v_cti, v_bte};
    if (own[k] == 2) em = {mi_cyc, mi_stb, mi_we, mi_adr, mi_dat, mi_sel, mi_cti, mi_bte};
    am = {o_cyc[k], o_stb[k], o_we[k], o_adr[k], o_dat[k], o_sel[k], o_cti[k], o_bte[k]};
    er = {(own[k] == 1) ? {s_ack, s_err, s_rty} : 3'b000,
          (own[k] == 2) ? {s_ack, s_err, s_rty} : 3'b000};
    ar = {o_vack[k], o_verr[k], o_vrty[k], o_mack[k], o_merr[k], o_mrty[k]};
    cmp("master_side", k, 128'(am), 128'(em));
    cmp("responses", k, 128'(ar), 128'(er));
    cmp("grants", k, 128'({o_gv[k], o_gm[k]}), 128'({own[k] == 1, own[k] == 2}));
    cmp("dat_sm", k, 128'({o_vdat[k], o_mdat[k]}), 128'({s_dat, s_dat}));
    vacks[k] += int'(o_vack[k]);
    macks[k] += int'(o_mack[k]);
  endtask

  // one falling-edge sample: compare, then advance the model past the
  // next rising edge (inputs stay stable until then)
  task automatic sample();
    @(negedge clk);
    cyc_n++;
    if (!rst_n) model_reset();
    for (int k = 0; k < 2; k++) check_inst(k);
    if (rst_n) for (int k = 0; k < 2; k++) model_step(k);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    for (int k = 0; k < 2; k++) begin
      vacks[k] = 0; macks[k] = 0;
    end
  endtask

  task automatic idle_inputs();
    v_cyc = 0; v_stb = 0; v_we = 0; mi_cyc = 0; mi_stb = 0; mi_we = 0;
    s_ack = 0; s_err = 0; s_rty = 0;
  endtask

  task automatic rand_data();
    v_adr = $urandom; v_dat = $urandom; mi_adr = $urandom; mi_dat = $urandom;
    s_dat = $urandom;
    v_sel = 4'($urandom); mi_sel = 4'($urandom);
    v_cti = 3'($urandom); mi_cti = 3'($urandom);
    v_bte = 2'($urandom); mi_bte = 2'($urandom);
  endtask

  task automatic do_reset();
    tick();
    rst_n = 0;
    idle_inputs();
    sample();
    tick();
    sample();
  endtask

  task automatic lit(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0d want=%0d", name, cyc_n, act, exp);
    end
  endtask

  initial begin
    rst_n = 0;
    idle_inputs();
    rand_data();
    model_reset();
    clr_counts();
    sample();
    lit("reset_gnt", int'({o_gv[0], o_gm[0]}), 0);
    lit("reset_cyc", int'({o_cyc[0], o_stb[0]}), 0);

    // VGA alone, slave acks every cycle
    do_reset();
    tick(); rst_n = 1; v_cyc = 1; v_stb = 1; v_we = 0; s_ack = 1; clr_counts();
    sample();
    lit("vga_alone_idle", int'(o_gv[0]), 0);
    for (int i = 0; i < 39; i++) begin
      tick(); rand_data();
      sample();
      if (i == 0) lit("vga_alone_gnt", int'(o_gv[0]), 1);
    end
    lit("vga_alone_acks16", vacks[0], 39);
    lit("vga_alone_acks1", vacks[1], 39);
    lit("vga_alone_mire", macks[0] + macks[1], 0);

    // both request from reset: 16/16 split, and 1/1 split for MAX_BURST=1
    do_reset();
    tick(); rst_n = 1; v_cyc = 1; v_stb = 1; mi_cyc = 1; mi_stb = 1; mi_we = 1;
    s_ack = 1; clr_counts();
    sample();
    for (int i = 1; i <= 64; i++) begin
      tick(); rand_data();
      sample();
      if (i == 1)  lit("both_first_vga", int'(o_gv[0]), 1);
      if (i == 16) lit("both_vga_16th", int'(o_gv[0]), 1);
      if (i == 17) lit("both_handover", int'({o_gm[0], o_we[0]}), 3);
      if (i == 2)  lit("alt_mire", int'(o_gm[1]), 1);
      if (i == 3)  lit("alt_vga", int'(o_gv[1]), 1);
    end
    lit("both_vacks16", vacks[0], 32);
    lit("both_macks16", macks[0], 32);
    lit("both_vacks1", vacks[1], 32);
    lit("both_macks1", macks[1], 32);

    // mire: 3 transfers then drops while VGA pending
    do_reset();
    tick(); rst_n = 1; mi_cyc = 1; mi_stb = 1; s_ack = 1; clr_counts();
    sample();
    for (int i = 1; i <= 5; i++) begin
      tick(); rand_data();
      if (i == 2) begin v_cyc = 1; v_stb = 1; end
      if (i == 4) begin mi_cyc = 0; mi_stb = 0; s_ack = 0; end
      if (i == 5) s_ack = 1;
      sample();
      if (i == 4) lit("drop_still_mire", int'(o_gm[0]), 1);
      if (i == 5) lit("drop_direct_vga", int'(o_gv[0]), 1);
    end
    lit("drop_mire_acks", macks[0], 3);

    // randomized traffic with err/rty
    do_reset();
    tick(); rst_n = 1;
    for (int i = 0; i < 2500; i++) begin
      int r;
      if (i != 0) tick();
      rand_data();
      v_cyc = ($urandom_range(0, 19) != 0);
      v_stb = ($urandom_range(0, 4) != 0);
      v_we  = 1'($urandom);
      if ($urandom_range(0, 9) == 0) mi_cyc = ~mi_cyc;
      mi_stb = mi_cyc & ($urandom_range(0, 3) != 0);
      mi_we  = 1'($urandom);
      r = $urandom_range(0, 9);
      s_ack = (r <= 5);
      s_err = (r == 6);
      s_rty = (r == 7);
      sample();
    end

    // reset mid-burst while mire owns
    do_reset();
    tick(); rst_n = 1; idle_inputs(); mi_cyc = 1; mi_stb = 1; s_ack = 1;
    sample();
    for (int i = 1; i <= 3; i++) begin
      tick(); rand_data();
      if (i == 3) begin v_cyc = 1; v_stb = 1; end
      sample();
    end
    lit("midburst_owner", int'(o_gm[0]), 1);
    tick(); rst_n = 0;
    sample();
    lit("midburst_gnt", int'(o_gm[0]), 0);
    lit("midburst_cyc", int'({o_cyc[0], o_stb[0]}), 0);
    lit("midburst_ack", int'(o_mack[0]), 0);
    tick(); rst_n = 1;
    sample();
    tick();
    sample();
    lit("after_reset_vga", int'(o_gv[0]), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
